// File: rtl/spi_ram_ctrl_pkg.sv
// Shared definitions for the SPI-to-RAM controller: frame layout, command
// codes, SPI FSM states and arbiter grant identifiers.
package spi_ram_ctrl_pkg;

  localparam int unsigned FRAME_W   = 10;
  localparam int unsigned CMD_W     = 2;
  localparam int unsigned PAYLOAD_W = 8;
  localparam int unsigned NUM_REQ   = 2;

  // Bit positions of each requester in the arbiter req/gnt vectors
  localparam int unsigned IDX_SPI  = 0;
  localparam int unsigned IDX_HOST = 1;

  localparam logic [CMD_W-1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [CMD_W-1:0] CMD_WR_DATA = 2'b01;
  localparam logic [CMD_W-1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [CMD_W-1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PEND = 2'b01,
    S_RDW  = 2'b10,
    S_TX   = 2'b11
  } spi_state_t;

  typedef enum logic {
    GNT_SPI  = 1'b0,
    GNT_HOST = 1'b1
  } grant_id_t;

endpackage

// File: rtl/spi_ram_ctrl_arbiter.sv
// Two-requester round-robin arbiter for the single RAM port; on a tie the
// requester that was not granted last wins.
module ram_rr_arbiter
  import spi_ram_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output grant_id_t          last_grant
);

  always_comb begin
    gnt = '0;
    if (req[IDX_SPI] && (!req[IDX_HOST] || last_grant == GNT_HOST)) begin
      gnt[IDX_SPI] = 1'b1;
    end else if (req[IDX_HOST]) begin
      gnt[IDX_HOST] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= GNT_HOST;
    end else if (gnt[IDX_SPI]) begin
      last_grant <= GNT_SPI;
    end else if (gnt[IDX_HOST]) begin
      last_grant <= GNT_HOST;
    end
  end

endmodule

// File: rtl/spi_ram_ctrl.sv
// Decodes SPI frames into RAM accesses, shares the RAM port with a local host
// and returns SPI read data to the slave for shifting out on MISO.
module spi_ram_ctrl
  import spi_ram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FRAME_W-1:0]    rx_data,
  input  logic                  rx_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  h_req,
  input  logic                  h_we,
  input  logic [ADDR_WIDTH-1:0] h_addr,
  input  logic [DATA_WIDTH-1:0] h_wdata,
  output logic                  h_gnt,
  output logic                  h_rvalid,
  output logic [DATA_WIDTH-1:0] h_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  spi_ovf
);

  spi_state_t state, state_nxt;

  logic                  rx_valid_q;
  logic                  frame_edge;
  logic [CMD_W-1:0]      cmd;
  logic [PAYLOAD_W-1:0]  payload;
  logic                  data_frame;

  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  pend_we;
  logic [ADDR_WIDTH-1:0] pend_addr;
  logic [DATA_WIDTH-1:0] pend_wdata;

  logic                  spi_req;
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    gnt;
  logic                  gnt_spi;
  logic                  gnt_host;
  grant_id_t             last_grant_unused;

  assign frame_edge = rx_valid && !rx_valid_q;
  assign cmd        = rx_data[FRAME_W-1:PAYLOAD_W];
  assign payload    = rx_data[PAYLOAD_W-1:0];
  assign data_frame = frame_edge && (cmd == CMD_WR_DATA || cmd == CMD_RD_DATA);

  // Requests are masked during reset so no strobe leaks out while rst is high
  assign req[IDX_SPI]  = !rst && spi_req;
  assign req[IDX_HOST] = !rst && h_req && !h_rvalid;
  assign gnt_spi       = gnt[IDX_SPI];
  assign gnt_host      = gnt[IDX_HOST];

  ram_rr_arbiter u_arb (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .gnt        (gnt),
    .last_grant (last_grant_unused)
  );

  // SPI FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // SPI FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (data_frame) state_nxt = S_PEND;
      S_PEND: if (gnt_spi) state_nxt = pend_we ? S_IDLE : S_RDW;
      S_RDW:  state_nxt = rx_valid ? S_TX : S_IDLE;
      S_TX:   if (!rx_valid) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // SPI FSM outputs; tx_valid drops in the same cycle rx_valid falls
  always_comb begin
    spi_req  = 1'b0;
    tx_valid = 1'b0;
    case (state)
      S_PEND:  spi_req  = 1'b1;
      S_TX:    tx_valid = rx_valid;
      default: ;
    endcase
  end

  // Frame decode, pending op capture, overrun flag and read data capture.
  // rx_valid_q resets high so a level still held across reset is not a new frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_valid_q <= 1'b1;
      wr_addr    <= '0;
      rd_addr    <= '0;
      pend_we    <= 1'b0;
      pend_addr  <= '0;
      pend_wdata <= '0;
      spi_ovf    <= 1'b0;
      tx_data    <= '0;
      h_rvalid   <= 1'b0;
    end else begin
      rx_valid_q <= rx_valid;
      if (frame_edge && cmd == CMD_WR_ADDR) wr_addr <= ADDR_WIDTH'(payload);
      if (frame_edge && cmd == CMD_RD_ADDR) rd_addr <= ADDR_WIDTH'(payload);
      if (data_frame) begin
        if (state == S_IDLE) begin
          pend_we   <= (cmd == CMD_WR_DATA);
          pend_addr <= (cmd == CMD_WR_DATA) ? wr_addr : rd_addr;
          if (cmd == CMD_WR_DATA) pend_wdata <= DATA_WIDTH'(payload);
        end else begin
          spi_ovf <= 1'b1;
        end
      end
      if (state == S_RDW && rx_valid) tx_data <= mem_dout;
      h_rvalid <= gnt_host && !h_we;
    end
  end

  // RAM port driven by the current winner; idle port shows zeros
  always_comb begin
    mem_en   = gnt_spi || gnt_host;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (gnt_spi) begin
      mem_we   = pend_we;
      mem_addr = pend_addr;
      mem_din  = pend_wdata;
    end else if (gnt_host) begin
      mem_we   = h_we;
      mem_addr = h_addr;
      mem_din  = h_wdata;
    end
  end

  assign h_gnt   = gnt_host;
  assign h_rdata = h_rvalid ? mem_dout : '0;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed bench for spi_ram_ctrl with a behavioural one-cycle-latency RAM
// whose unwritten locations read as (addr ^ 8'hC3).
module tb_spi_ram_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       h_req;
  logic       h_we;
  logic [7:0] h_addr;
  logic [7:0] h_wdata;
  logic       h_gnt;
  logic       h_rvalid;
  logic [7:0] h_rdata;
  logic       mem_en;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_din;
  logic [7:0] mem_dout = '0;
  logic       spi_ovf;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [7:0] ram [256];
  bit         written [256];

  always #5 clk = ~clk;

  spi_ram_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .h_req    (h_req),
    .h_we     (h_we),
    .h_addr   (h_addr),
    .h_wdata  (h_wdata),
    .h_gnt    (h_gnt),
    .h_rvalid (h_rvalid),
    .h_rdata  (h_rdata),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout),
    .spi_ovf  (spi_ovf)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr]     <= mem_din;
        written[mem_addr] <= 1'b1;
      end else begin
        mem_dout <= written[mem_addr] ? ram[mem_addr] : (mem_addr ^ 8'hC3);
      end
    end
  end

  task automatic send_frame(input logic [1:0] c, input logic [7:0] p);
    @(negedge clk);
    rx_data  = {c, p};
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; rx_valid = 1'b0; rx_data = '0;
    h_req = 1'b0; h_we = 1'b0; h_addr = '0; h_wdata = '0;
    repeat (2) @(negedge clk);
    #1;
    total_cnt++;
    if ({tx_data, tx_valid, h_gnt, h_rvalid, h_rdata, mem_en, mem_we, mem_addr, mem_din, spi_ovf} !== 38'd0)
      $display("FAIL reset_in: outputs got %h exp 0",
               {tx_data, tx_valid, h_gnt, h_rvalid, h_rdata, mem_en, mem_we, mem_addr, mem_din, spi_ovf});
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total_cnt++;
    if ({tx_valid, h_gnt, h_rvalid, mem_en, spi_ovf} !== 5'd0)
      $display("FAIL reset_out: flags got %b exp 00000", {tx_valid, h_gnt, h_rvalid, mem_en, spi_ovf});
    else pass_cnt++;
  endtask

  task automatic test_spi_write;
    send_frame(2'b00, 8'h35);
    @(negedge clk);
    rx_data = {2'b01, 8'hA7}; rx_valid = 1'b1;
    #1;
    total_cnt++;
    if (mem_en !== 1'b0) $display("FAIL wr_edge_cycle: mem_en got %b exp 0", mem_en);
    else pass_cnt++;
    @(negedge clk);
    rx_valid = 1'b0;
    #1;
    total_cnt++;
    if ({mem_en, mem_we, mem_addr, mem_din, h_gnt} !== {1'b1, 1'b1, 8'h35, 8'hA7, 1'b0})
      $display("FAIL wr_strobe: en/we/addr/din/hgnt got %b/%b/%h/%h/%b exp 1/1/35/a7/0",
               mem_en, mem_we, mem_addr, mem_din, h_gnt);
    else pass_cnt++;
    @(negedge clk);
    #1;
    total_cnt++;
    if ({mem_en, spi_ovf} !== 2'b00) $display("FAIL wr_after: en/ovf got %b/%b exp 0/0", mem_en, spi_ovf);
    else pass_cnt++;
  endtask

  task automatic test_spi_read;
    send_frame(2'b10, 8'h35);
    @(negedge clk);
    rx_data = {2'b11, 8'h00}; rx_valid = 1'b1;
    @(negedge clk);
    #1;
    total_cnt++;
    if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 8'h35})
      $display("FAIL rd_strobe: en/we/addr got %b/%b/%h exp 1/0/35", mem_en, mem_we, mem_addr);
    else pass_cnt++;
    @(negedge clk);
    #1;
    total_cnt++;
    if (tx_valid !== 1'b0) $display("FAIL rd_rdw: tx_valid got %b exp 0", tx_valid);
    else pass_cnt++;
    @(negedge clk);
    #1;
    total_cnt++;
    if ({tx_valid, tx_data} !== {1'b1, 8'hA7})
      $display("FAIL rd_tx: tx_valid/tx_data got %b/%h exp 1/a7", tx_valid, tx_data);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    #1;
    total_cnt++;
    if ({tx_valid, tx_data} !== {1'b1, 8'hA7})
      $display("FAIL rd_hold: tx_valid/tx_data got %b/%h exp 1/a7", tx_valid, tx_data);
    else pass_cnt++;
    @(negedge clk);
    rx_valid = 1'b0;
    #1;
    total_cnt++;
    if (tx_valid !== 1'b0) $display("FAIL rd_drop: tx_valid got %b exp 0", tx_valid);
    else pass_cnt++;
    @(negedge clk);
    #1;
    total_cnt++;
    if (tx_valid !== 1'b0) $display("FAIL rd_idle: tx_valid got %b exp 0", tx_valid);
    else pass_cnt++;
  endtask

  task automatic test_tie_arbitration;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    send_frame(2'b00, 8'h20);
    @(negedge clk);
    rx_data = {2'b01, 8'h66}; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; h_req = 1'b1; h_we = 1'b0; h_addr = 8'h10; h_wdata = 8'h00;
    #1;
    total_cnt++;
    if ({mem_en, mem_we, mem_addr, mem_din, h_gnt} !== {1'b1, 1'b1, 8'h20, 8'h66, 1'b0})
      $display("FAIL tie1_spi: en/we/addr/din/hgnt got %b/%b/%h/%h/%b exp 1/1/20/66/0",
               mem_en, mem_we, mem_addr, mem_din, h_gnt);
    else pass_cnt++;
    @(negedge clk);
    #1;
    total_cnt++;
    if ({h_gnt, mem_en, mem_we, mem_addr} !== {1'b1, 1'b1, 1'b0, 8'h10})
      $display("FAIL tie1_host: hgnt/en/we/addr got %b/%b/%b/%h exp 1/1/0/10", h_gnt, mem_en, mem_we, mem_addr);
    else pass_cnt++;
    @(negedge clk);
    h_req = 1'b0;
    #1;
    total_cnt++;
    if ({h_rvalid, h_rdata, h_gnt} !== {1'b1, 8'hD3, 1'b0})
      $display("FAIL tie1_rdata: rvalid/rdata/hgnt got %b/%h/%b exp 1/d3/0", h_rvalid, h_rdata, h_gnt);
    else pass_cnt++;
    // lone SPI write leaves last_grant on SPI
    @(negedge clk);
    rx_data = {2'b01, 8'h77}; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    #1;
    total_cnt++;
    if ({mem_en, mem_we, mem_din, h_gnt} !== {1'b1, 1'b1, 8'h77, 1'b0})
      $display("FAIL solo_spi: en/we/din/hgnt got %b/%b/%h/%b exp 1/1/77/0", mem_en, mem_we, mem_din, h_gnt);
    else pass_cnt++;
    @(negedge clk);
    rx_data = {2'b01, 8'h88}; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; h_req = 1'b1; h_we = 1'b0; h_addr = 8'h10;
    #1;
    total_cnt++;
    if ({h_gnt, mem_we, mem_addr} !== {1'b1, 1'b0, 8'h10})
      $display("FAIL tie2_host: hgnt/we/addr got %b/%b/%h exp 1/0/10", h_gnt, mem_we, mem_addr);
    else pass_cnt++;
    @(negedge clk);
    h_req = 1'b0;
    #1;
    total_cnt++;
    if ({h_rvalid, h_rdata, mem_en, mem_we, mem_addr, mem_din, h_gnt} !==
        {1'b1, 8'hD3, 1'b1, 1'b1, 8'h20, 8'h88, 1'b0})
      $display("FAIL tie2_spi: rvalid/rdata/en/we/addr/din/hgnt got %b/%h/%b/%b/%h/%h/%b exp 1/d3/1/1/20/88/0",
               h_rvalid, h_rdata, mem_en, mem_we, mem_addr, mem_din, h_gnt);
    else pass_cnt++;
    @(negedge clk);
    #1;
    total_cnt++;
    if ({mem_en, h_rvalid} !== 2'b00) $display("FAIL tie2_idle: en/rvalid got %b/%b exp 0/0", mem_en, h_rvalid);
    else pass_cnt++;
  endtask

  task automatic test_held_level;
    int n = 0;
    @(negedge clk);
    rx_data = {2'b01, 8'h5A}; rx_valid = 1'b1;
    repeat (21) begin
      @(negedge clk);
      #1;
      if (mem_en && mem_we) n++;
    end
    rx_valid = 1'b0;
    total_cnt++;
    if (n !== 1) $display("FAIL held_writes: count got %0d exp 1", n);
    else pass_cnt++;
    total_cnt++;
    if (spi_ovf !== 1'b0) $display("FAIL held_ovf: spi_ovf got %b exp 0", spi_ovf);
    else pass_cnt++;
  endtask

  task automatic test_overrun;
    int n = 0;
    @(negedge clk);
    rx_data = {2'b01, 8'h11}; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; h_req = 1'b1; h_we = 1'b1; h_addr = 8'h40; h_wdata = 8'h99;
    #1;
    total_cnt++;
    if ({h_gnt, mem_we, mem_addr, mem_din} !== {1'b1, 1'b1, 8'h40, 8'h99})
      $display("FAIL ovr_host_first: hgnt/we/addr/din got %b/%b/%h/%h exp 1/1/40/99",
               h_gnt, mem_we, mem_addr, mem_din);
    else pass_cnt++;
    @(negedge clk);
    rx_data = {2'b01, 8'h22}; rx_valid = 1'b1;
    #1;
    total_cnt++;
    if ({h_gnt, mem_en, mem_we, mem_addr, mem_din, spi_ovf} !== {1'b0, 1'b1, 1'b1, 8'h20, 8'h11, 1'b0})
      $display("FAIL ovr_first_done: hgnt/en/we/addr/din/ovf got %b/%b/%b/%h/%h/%b exp 0/1/1/20/11/0",
               h_gnt, mem_en, mem_we, mem_addr, mem_din, spi_ovf);
    else pass_cnt++;
    @(negedge clk);
    rx_valid = 1'b0;
    #1;
    total_cnt++;
    if ({spi_ovf, h_gnt} !== 2'b11) $display("FAIL ovr_flag: ovf/hgnt got %b/%b exp 1/1", spi_ovf, h_gnt);
    else pass_cnt++;
    repeat (10) begin
      @(negedge clk);
      #1;
      if (mem_en && !h_gnt) n++;
    end
    h_req = 1'b0; h_we = 1'b0;
    total_cnt++;
    if (n !== 0) $display("FAIL ovr_dropped: spi strobes got %0d exp 0", n);
    else pass_cnt++;
  endtask

  task automatic test_reset_in_rdw;
    int n = 0;
    send_frame(2'b10, 8'h10);
    @(negedge clk);
    rx_data = {2'b11, 8'h00}; rx_valid = 1'b1;
    @(negedge clk);
    #1;
    total_cnt++;
    if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 8'h10})
      $display("FAIL rst_setup: en/we/addr got %b/%b/%h exp 1/0/10", mem_en, mem_we, mem_addr);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b1; rx_valid = 1'b0;
    @(negedge clk);
    #1;
    total_cnt++;
    if ({tx_data, tx_valid, h_gnt, h_rvalid, h_rdata, mem_en, mem_we, mem_addr, mem_din, spi_ovf} !== 38'd0)
      $display("FAIL rst_rdw: outputs got %h exp 0",
               {tx_data, tx_valid, h_gnt, h_rvalid, h_rdata, mem_en, mem_we, mem_addr, mem_din, spi_ovf});
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      #1;
      if (mem_en || tx_valid) n++;
    end
    total_cnt++;
    if (n !== 0) $display("FAIL rst_quiet: active cycles got %0d exp 0", n);
    else pass_cnt++;
    @(negedge clk);
    rx_data = {2'b11, 8'hFF}; rx_valid = 1'b1;
    @(negedge clk);
    #1;
    total_cnt++;
    if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 8'h00})
      $display("FAIL rst_rd0_strobe: en/we/addr got %b/%b/%h exp 1/0/00", mem_en, mem_we, mem_addr);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    #1;
    total_cnt++;
    if ({tx_valid, tx_data} !== {1'b1, 8'hC3})
      $display("FAIL rst_rd0_data: tx_valid/tx_data got %b/%h exp 1/c3", tx_valid, tx_data);
    else pass_cnt++;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_spi_write();
    test_spi_read();
    test_tie_arbitration();
    test_held_level();
    test_overrun();
    test_reset_in_rdw();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", pass_cnt, total_cnt);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/spi_ram_ctrl.md
Name: spi_ram_ctrl

Overview:
Sits between the SPI slave frame interface and the single-port RAM. Decodes 10-bit SPI frames into address-latch, write and read operations. Shares the one RAM port round-robin between the SPI path and a local host port. Returns SPI read data on tx_data/tx_valid for the slave to shift out on MISO.

Parameters:
ADDR_WIDTH, 8, RAM address width; equals SPI frame payload width
DATA_WIDTH, 8, RAM data width; equals tx_data width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
rx_data  in  10  SPI frame; [9:8] command, [7:0] payload
rx_valid  in  1  level from SPI slave; high from frame completion until SS_n deasserts
tx_data  out  DATA_WIDTH  read data to SPI slave
tx_valid  out  1  held high while tx_data is valid for shifting
h_req  in  1  host access request; held with stable fields until h_gnt
h_we  in  1  host write (1) / read (0)
h_addr  in  ADDR_WIDTH  host address
h_wdata  in  DATA_WIDTH  host write data
h_gnt  out  1  one-cycle pulse; host access issued to RAM this cycle
h_rvalid  out  1  one-cycle pulse; h_rdata valid (cycle after read grant)
h_rdata  out  DATA_WIDTH  host read data
mem_en  out  1  RAM access strobe
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_WIDTH  RAM address
mem_din  out  DATA_WIDTH  RAM write data
mem_dout  in  DATA_WIDTH  RAM read data; valid 1 cycle after read strobe
spi_ovf  out  1  sticky; new SPI frame arrived while previous SPI op still pending

Behaviour:
- Reset (async): all outputs 0; wr_addr=0, rd_addr=0, last_grant=HOST (SPI wins first tie), FSM=S_IDLE, pending flags cleared. Reset mid-access discards the in-flight op; no RAM strobe follows reset release until a new request arrives.
- Frame accept: only on rx_valid rising edge (registered rx_valid_q). A level held high never re-triggers.
- Commands by rx_data[9:8]:
  - 00: wr_addr <= payload; no RAM access.
  - 01: SPI write pending, addr=wr_addr, data=payload.
  - 10: rd_addr <= payload; no RAM access.
  - 11: SPI read pending, addr=rd_addr.
  - The payload of a read frame is ignored.
- SPI FSM:
  - S_IDLE -> S_PEND on accepted 01/11 frame.
  - S_PEND -> S_IDLE on grant of a write.
  - S_PEND -> S_RDW on grant of a read.
  - S_RDW (one cycle): capture mem_dout into tx_data. Go to S_TX if rx_valid is still high, else S_IDLE (aborted frame, data discarded).
  - S_TX: tx_valid=1 while tx_data is held; -> S_IDLE when rx_valid falls, clearing tx_valid the same cycle.
- Overrun: accepted 01/11 edge while FSM is not S_IDLE -> frame dropped, spi_ovf <= 1. A 00/10 edge in that case still updates its address register.
- Arbiter:
  - One RAM access per cycle.
  - Requesters are SPI (FSM in S_PEND) and host (h_req, with no host read awaiting return).
  - Single requester -> granted immediately.
  - Both requesting -> the one not in last_grant wins; last_grant updates on every grant.
  - Grant cycle drives mem_en=1 with mem_we/mem_addr/mem_din from the winner. mem_en=0 otherwise; mem_addr/mem_din may hold their last values.
- Host read latency: h_gnt at cycle T, h_rvalid and h_rdata=mem_dout at T+1.
- Host write: complete at h_gnt.
- Worst-case SPI latency, frame edge to RAM strobe: 2 cycles (edge detect, one lost tie).
- Address arithmetic: no increment or wrap; addresses used as latched.

Decomposition:
- Shared package holds:
  - command codes CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11;
  - SPI FSM state encodings S_IDLE/S_PEND/S_RDW/S_TX;
  - grant IDs GNT_SPI/GNT_HOST.
- Sub-module ram_rr_arbiter: 2-requester round-robin, inputs req[1:0], outputs one-hot gnt and last_grant register. Everything else lives in spi_ram_ctrl.

Test Plan:
1. Frames 00_0x35 then 01_0xA7 -> one cycle with mem_en=1, mem_we=1, mem_addr=0x35, mem_din=0xA7; no h_gnt; spi_ovf=0.
2. Frames 10_0x35 then 11_xx with RAM returning 0xA7 -> tx_data=0xA7, tx_valid=1 until rx_valid falls, then 0 the same cycle.
3. Tie arbitration:
   - Setup: SPI write pending and h_req=1 read at 0x10, both in the same cycle.
   - First grant -> SPI, since reset state is last_grant=HOST.
   - Next cycle -> h_gnt; following cycle -> h_rvalid=1 with h_rdata=mem_dout.
   - Repeating the tie next time -> host granted first.
4. rx_valid held high for 20 cycles after one 01 frame -> exactly one RAM write.
5. Overrun: second 01 edge while first is still in S_PEND under continuous host traffic -> spi_ovf=1, second write never issued, first completes.
6. Assert rst during S_RDW -> next cycle all outputs 0 and FSM in S_IDLE. After release, 11 frame reads address 0x00.
